// File: rtl/instruction_memory_banked_pkg.sv
// ---------------------------------------------------------------------------
// instruction_memory_banked_pkg
// Shared definitions for the banked instruction memory:
//   - load/run FSM state encoding and its width
//   - output source selector for the fetched-instruction register
//   - INSTRUCTION_HALT encoding that terminates a program load
//   - clear_word(): all-zero word of a given width, used to blank vectors
// Optional feature macro used by the files importing this package:
//   INSTRUCTION_MEMORY_READBACK_EN
// ---------------------------------------------------------------------------
package instruction_memory_banked_pkg;

   localparam int STATE_WIDTH = 3;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_READY = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERROR = 3'd4
   } state_e;

   // Source of o_instruction: nothing fetched yet, the bank read register,
   // or the HALT encoding substituted for an out-of-range PC.
   typedef enum logic [1:0] {
      OUT_ZERO = 2'd0,
      OUT_MEM  = 2'd1,
      OUT_HALT = 2'd2
   } out_sel_e;

   localparam logic [31:0] INSTRUCTION_HALT = 32'hFFFF_FFFF;

   // Returns a zero word; n is kept for call-site readability only.
   function automatic logic [31:0] clear_word(input int unsigned n);
      clear_word = (n == 0) ? 32'd0 : 32'd0;
   endfunction

endpackage

// File: rtl/instruction_memory_banked_bank.sv
// ---------------------------------------------------------------------------
// instruction_memory_banked_bank
// DEPTH x REG_SIZE instruction array with one synchronous write port and one
// registered read port (read register updates only when rd_en_i is high, so
// the caller can freeze it). With INSTRUCTION_MEMORY_READBACK_EN a second,
// always-enabled registered read port is added for the debug unit.
// Ports:
//   clk_i                 clock
//   wr_en_i/addr/data     write port
//   rd_en_i/addr, rd_data_o   main registered read port
//   rst_n_i, dbg_addr_i, dbg_data_o   debug read port (macro only)
// ---------------------------------------------------------------------------
module instruction_memory_banked_bank #(
   parameter int REG_SIZE = 32,
   parameter int DEPTH    = 64,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic                clk_i,
   input  logic                wr_en_i,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic [REG_SIZE-1:0] wr_data_i,
   input  logic                rd_en_i,
   input  logic [ADDR_W-1:0]   rd_addr_i,
   output logic [REG_SIZE-1:0] rd_data_o
`ifdef INSTRUCTION_MEMORY_READBACK_EN
   ,
   input  logic                rst_n_i,
   input  logic [ADDR_W-1:0]   dbg_addr_i,
   output logic [REG_SIZE-1:0] dbg_data_o
`endif
);

   logic [REG_SIZE-1:0] mem_q [DEPTH];
   logic [REG_SIZE-1:0] rd_data_q;

   // No reset on the array or its read register so they map onto block RAM;
   // the top masks rd_data_o until a real fetch has happened.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

`ifdef INSTRUCTION_MEMORY_READBACK_EN
   logic [REG_SIZE-1:0] dbg_data_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dbg_data_q <= '0;
      end else begin
         dbg_data_q <= mem_q[dbg_addr_i];
      end
   end

   assign dbg_data_o = dbg_data_q;
`endif

endmodule

// File: rtl/instruction_memory_banked.sv
// ---------------------------------------------------------------------------
// instruction_memory_banked
// Instruction store for the IF stage. A program is streamed in one word per
// cycle over a valid/ready port until the HALT encoding arrives; afterwards
// one registered instruction per cycle is served, indexed by a byte PC.
// Ports:
//   i_clk, i_reset (async, active-low), i_clear (sync program discard)
//   i_write_valid / o_write_ready / i_instruction   load port
//   i_start, i_stall, i_pc                          execution control / fetch
//   o_instruction                                   registered fetch result
//   o_loaded, o_error, o_count                      status
//   i_rd_addr / o_rd_data                           debug readback (macro)
// Optional feature: INSTRUCTION_MEMORY_READBACK_EN adds the debug read port.
// ---------------------------------------------------------------------------
module instruction_memory_banked
   import instruction_memory_banked_pkg::*;
#(
   parameter int REG_SIZE = 32,
   parameter int DEPTH    = 64,
   parameter int PC_WIDTH = 32
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_clear,
   input  logic                     i_write_valid,
   output logic                     o_write_ready,
   input  logic [REG_SIZE-1:0]      i_instruction,
   input  logic                     i_start,
   input  logic                     i_stall,
   input  logic [PC_WIDTH-1:0]      i_pc,
   output logic [REG_SIZE-1:0]      o_instruction,
   output logic                     o_loaded,
   output logic                     o_error,
   output logic [$clog2(DEPTH):0]   o_count
`ifdef INSTRUCTION_MEMORY_READBACK_EN
   ,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [REG_SIZE-1:0]      o_rd_data
`endif
);

   localparam int ADDR_W     = $clog2(DEPTH);
   localparam int CNT_W      = ADDR_W + 1;
   localparam int BYTE_SHIFT = $clog2(REG_SIZE / 8);
   localparam logic [REG_SIZE-1:0] HALT_WORD = REG_SIZE'(INSTRUCTION_HALT);

   state_e              state_q,   state_d;
   out_sel_e            out_sel_q, out_sel_d;
   logic [ADDR_W-1:0]   wr_ptr_q,  wr_ptr_d;
   logic [CNT_W-1:0]    count_q,   count_d;

   logic                wr_fire;
   logic                is_halt;
   logic [PC_WIDTH-1:0] word_idx;
   logic                in_range;
   logic                rd_en;
   logic [ADDR_W-1:0]   rd_addr;
   logic [REG_SIZE-1:0] rd_data;

   // ---------------- state registers ----------------
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= ST_IDLE;
         out_sel_q <= OUT_ZERO;
         wr_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         out_sel_q <= out_sel_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
      end
   end

   // ---------------- next-state / control ----------------
   always_comb begin
      state_d   = state_q;
      out_sel_d = out_sel_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      rd_en     = 1'b0;
      rd_addr   = '0;

      // Clear wins over a same-cycle write, so it also blocks the store.
      wr_fire  = i_write_valid && o_write_ready && !i_clear;
      is_halt  = (i_instruction == HALT_WORD);
      // Whole PC feeds the shift; the dropped low bits are the byte offset.
      word_idx = i_pc >> BYTE_SHIFT;
      in_range = (word_idx < PC_WIDTH'(count_q));

      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         count_d  = count_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (wr_fire) begin
               state_d = is_halt ? ST_READY : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (wr_fire) begin
               if (is_halt) begin
                  state_d = ST_READY;
               end else if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                  // Array full without a terminator.
                  state_d = ST_ERROR;
               end
            end
         end
         ST_READY: begin
            // Keep slot 0 presented so the first instruction is ready at start.
            rd_en     = 1'b1;
            rd_addr   = '0;
            out_sel_d = OUT_MEM;
            if (i_start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!i_stall) begin
               if (in_range) begin
                  rd_en     = 1'b1;
                  rd_addr   = word_idx[ADDR_W-1:0];
                  out_sel_d = OUT_MEM;
               end else begin
                  out_sel_d = OUT_HALT;
               end
            end
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (i_clear) begin
         state_d  = ST_IDLE;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   // ---------------- storage ----------------
   instruction_memory_banked_bank #(
      .REG_SIZE (REG_SIZE),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W)
   ) u_bank (
      .clk_i      (i_clk),
      .wr_en_i    (wr_fire),
      .wr_addr_i  (wr_ptr_q),
      .wr_data_i  (i_instruction),
      .rd_en_i    (rd_en),
      .rd_addr_i  (rd_addr),
      .rd_data_o  (rd_data)
`ifdef INSTRUCTION_MEMORY_READBACK_EN
      ,
      .rst_n_i    (i_reset),
      .dbg_addr_i (i_rd_addr),
      .dbg_data_o (o_rd_data)
`endif
   );

   // ---------------- outputs ----------------
   always_comb begin
      case (out_sel_q)
         OUT_MEM:  o_instruction = rd_data;
         OUT_HALT: o_instruction = HALT_WORD;
         default:  o_instruction = REG_SIZE'(clear_word(REG_SIZE));
      endcase
   end

   assign o_write_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign o_loaded      = (state_q == ST_READY) || (state_q == ST_RUN);
   assign o_error       = (state_q == ST_ERROR);
   assign o_count       = count_q;

endmodule

// File: tb/tb_instruction_memory_banked.sv
module tb_instruction_memory_banked;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   // DEPTH = 64 instance
   logic        a_clear, a_wv, a_start, a_stall, a_ready, a_loaded, a_error;
   logic [31:0] a_din, a_pc, a_instr;
   logic [6:0]  a_count;

   // DEPTH = 4 instance
   logic        b_clear, b_wv, b_start, b_stall, b_ready, b_loaded, b_error;
   logic [31:0] b_din, b_pc, b_instr;
   logic [2:0]  b_count;

   int n_checks = 0;
   int n_pass   = 0;

   instruction_memory_banked #(.REG_SIZE(32), .DEPTH(64), .PC_WIDTH(32)) u_dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_clear       (a_clear),
      .i_write_valid (a_wv),
      .o_write_ready (a_ready),
      .i_instruction (a_din),
      .i_start       (a_start),
      .i_stall       (a_stall),
      .i_pc          (a_pc),
      .o_instruction (a_instr),
      .o_loaded      (a_loaded),
      .o_error       (a_error),
      .o_count       (a_count)
   );

   instruction_memory_banked #(.REG_SIZE(32), .DEPTH(4), .PC_WIDTH(32)) u_dut4 (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_clear       (b_clear),
      .i_write_valid (b_wv),
      .o_write_ready (b_ready),
      .i_instruction (b_din),
      .i_start       (b_start),
      .i_stall       (b_stall),
      .i_pc          (b_pc),
      .o_instruction (b_instr),
      .o_loaded      (b_loaded),
      .o_error       (b_error),
      .o_count       (b_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("check %-16s got 0x%0h expected 0x%0h ok", tag, got, exp);
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] pc_vec  [6] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd5};
   logic [31:0] exp_vec [6] = '{32'h11, 32'h22, 32'h33, HALT, HALT, 32'h22};
   logic [31:0] load_vec[4] = '{32'h11, 32'h22, 32'h33, HALT};

   initial begin
      rst_n   = 1'b0;
      a_clear = 0; a_wv = 0; a_start = 0; a_stall = 0; a_din = '0; a_pc = '0;
      b_clear = 0; b_wv = 0; b_start = 0; b_stall = 0; b_din = '0; b_pc = '0;
      #3;
      check_eq("rst_count",  a_count, 0);
      check_eq("rst_ready",  a_ready, 1);
      check_eq("rst_loaded", a_loaded, 0);
      check_eq("rst_error",  a_error, 0);
      check_eq("rst_instr",  a_instr, 0);
      tick();
      tick();
      rst_n = 1'b1;

      // Reset in the middle of a load aborts asynchronously.
      a_wv = 1;
      for (int i = 0; i < 3; i++) begin
         a_din = load_vec[i];
         tick();
      end
      a_wv = 0;
      check_eq("midload_count", a_count, 3);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_count",  a_count, 0);
      check_eq("arst_ready",  a_ready, 1);
      check_eq("arst_loaded", a_loaded, 0);
      tick();
      rst_n = 1'b1;

      // Full load terminated by HALT.
      a_wv = 1;
      for (int i = 0; i < 4; i++) begin
         a_din = load_vec[i];
         tick();
      end
      a_wv = 0;
      check_eq("load_count",  a_count, 4);
      check_eq("load_loaded", a_loaded, 1);
      check_eq("load_ready",  a_ready, 0);

      // READY: slot 0 appears; a write with ready low is ignored.
      a_wv  = 1;
      a_din = 32'h55;
      tick();
      a_wv = 0;
      check_eq("ready_instr", a_instr, 32'h11);
      check_eq("ready_count", a_count, 4);

      // Start, then fetch sequence.
      a_start = 1;
      tick();
      a_start = 0;
      check_eq("run_loaded", a_loaded, 1);
      for (int i = 0; i < 6; i++) begin
         a_pc = pc_vec[i];
         tick();
         check_eq($sformatf("fetch_pc%0d", pc_vec[i]), a_instr, exp_vec[i]);
      end

      // Stall freezes the output while the PC advances.
      a_pc = 0;
      tick();
      check_eq("prestall", a_instr, 32'h11);
      a_stall = 1;
      for (int i = 1; i <= 3; i++) begin
         a_pc = 32'(4 * i);
         tick();
         check_eq($sformatf("stall%0d", i), a_instr, 32'h11);
      end
      a_stall = 0;
      a_pc = 8;
      tick();
      check_eq("unstall", a_instr, 32'h33);

      // Clear from RUN.
      a_clear = 1;
      tick();
      a_clear = 0;
      check_eq("clr_count",  a_count, 0);
      check_eq("clr_loaded", a_loaded, 0);
      check_eq("clr_ready",  a_ready, 1);

      // Clear beats a same-cycle write in LOAD.
      a_wv  = 1;
      a_din = 32'hAA;
      tick();
      check_eq("idle_wr_count", a_count, 1);
      a_din   = 32'hBB;
      a_clear = 1;
      tick();
      a_clear = 0;
      a_wv    = 0;
      check_eq("clrwr_count", a_count, 0);
      check_eq("clrwr_ready", a_ready, 1);

      // DEPTH = 4 overflow into ERROR.
      b_wv = 1;
      for (int i = 1; i <= 4; i++) begin
         b_din = 32'(i);
         tick();
      end
      b_wv = 0;
      check_eq("ovf_error",  b_error, 1);
      check_eq("ovf_ready",  b_ready, 0);
      check_eq("ovf_count",  b_count, 4);
      check_eq("ovf_loaded", b_loaded, 0);
      b_start = 1;
      b_wv    = 1;
      b_din   = HALT;
      tick();
      b_start = 0;
      b_wv    = 0;
      check_eq("err_start",  b_loaded, 0);
      check_eq("err_error",  b_error, 1);
      check_eq("err_count",  b_count, 4);
      b_clear = 1;
      tick();
      b_clear = 0;
      check_eq("errclr_error", b_error, 0);
      check_eq("errclr_count", b_count, 0);
      check_eq("errclr_ready", b_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
